qsincos: RTL and testbench

QSINCOS -- requirements
Module: qsincos

---
 rtl/qsincos.sv | 134 +++++++++++++
 tb/tb_qsincos.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/qsincos.sv
// Iterative CORDIC sine/cosine generator: Q10 radian angle in, Q10 cos/sin out.
// One micro-rotation per clock; the input angle is folded into [-pi/2, pi/2] first.
module qsincos #(
  parameter int DATA_SIZE  = 32,
  parameter int ITERATIONS = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_signal,
  input  logic signed [DATA_SIZE-1:0] angle,
  output logic signed [DATA_SIZE-1:0] cos_out,
  output logic signed [DATA_SIZE-1:0] sin_out,
  output logic                        done_signal,
  output logic                        busy
);

  typedef logic signed [DATA_SIZE-1:0] data_t;

  localparam data_t HALF_PI = data_t'(1608);
  localparam data_t PI      = data_t'(3217);
  localparam data_t GAIN_K  = data_t'(622);
  localparam logic [3:0] ITER_LAST = 4'(ITERATIONS - 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, POST, WRITE} state_t;

  state_t      state, state_next;
  data_t       angle_lat;
  data_t       x, y, z;
  logic [3:0]  i;
  logic        negate;

  data_t       angle_clamped, z_fold, x_sh, y_sh;
  logic        negate_fold;

  function automatic data_t atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = data_t'(804);
      4'd1:    atan_lut = data_t'(475);
      4'd2:    atan_lut = data_t'(251);
      4'd3:    atan_lut = data_t'(127);
      4'd4:    atan_lut = data_t'(64);
      4'd5:    atan_lut = data_t'(32);
      4'd6:    atan_lut = data_t'(16);
      4'd7:    atan_lut = data_t'(8);
      4'd8:    atan_lut = data_t'(4);
      4'd9:    atan_lut = data_t'(2);
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic data_t clamp_angle(input data_t a);
    if (a > PI)       clamp_angle = PI;
    else if (a < -PI) clamp_angle = -PI;
    else              clamp_angle = a;
  endfunction

  // Quadrant folding: angles beyond +/-pi/2 are rotated by pi and the result negated.
  always_comb begin
    angle_clamped = clamp_angle(angle_lat);
    z_fold        = angle_clamped;
    negate_fold   = 1'b0;
    if (angle_clamped > HALF_PI) begin
      z_fold      = angle_clamped - PI;
      negate_fold = 1'b1;
    end else if (angle_clamped < -HALF_PI) begin
      z_fold      = angle_clamped + PI;
      negate_fold = 1'b1;
    end
    x_sh = x >>> i;
    y_sh = y >>> i;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_signal) state_next = PREP;
      PREP:    state_next = ITER;
      ITER:    if (i == ITER_LAST) state_next = POST;
      POST:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      angle_lat <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      negate    <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
    end else begin
      case (state)
        IDLE: if (start_signal) angle_lat <= angle;
        PREP: begin
          z      <= z_fold;
          negate <= negate_fold;
          x      <= GAIN_K;
          y      <= '0;
          i      <= '0;
        end
        ITER: begin
          if (!z[DATA_SIZE-1]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_lut(i);
          end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_lut(i);
          end
          i <= i + 4'd1;
        end
        POST: begin
          cos_out <= negate ? -x : x;
          sin_out <= negate ? -y : y;
        end
        default: ;
      endcase
    end
  end

  assign done_signal = (state == WRITE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_qsincos.sv
// Directed and random checks of qsincos against a real-valued trigonometric model.
module tb_qsincos;

  logic               clock = 1'b0;
  logic               reset;
  logic               start_signal;
  logic signed [31:0] angle;
  logic signed [31:0] cos_out, sin_out;
  logic               done_signal, busy;

  int n_assert = 0;
  int n_fail   = 0;

  qsincos #(.DATA_SIZE(32), .ITERATIONS(10)) dut (
    .clock(clock), .reset(reset), .start_signal(start_signal), .angle(angle),
    .cos_out(cos_out), .sin_out(sin_out), .done_signal(done_signal), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic int clamp_q10(input int a);
    if (a > 3217)  return 3217;
    if (a < -3217) return -3217;
    return a;
  endfunction

  function automatic int ref_cos(input int a);
    real th = real'(clamp_q10(a)) / 1024.0;
    return $rtoi($floor(1024.0 * $cos(th) + 0.5));
  endfunction

  function automatic int ref_sin(input int a);
    real th = real'(clamp_q10(a)) / 1024.0;
    return $rtoi($floor(1024.0 * $sin(th) + 0.5));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp);
    logic ok;
    ok = ((obs - exp) <= 4) && ((exp - obs) <= 4);
    n_assert++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/-4", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one sampling edge, then wait (bounded) for done; lat is the cycle index of done.
  task automatic run_op(input int a, output int lat);
    start_signal = 1'b1;
    angle        = a;
    tick();
    start_signal = 1'b0;
    angle        = $urandom;
    lat = 1;
    while (!done_signal && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_angle(input string tag, input int a, input int ec, input int es);
    int lat;
    run_op(a, lat);
    chk({tag, "_lat"}, lat, 13);
    chk_tol({tag, "_cos"}, cos_out, ec);
    chk_tol({tag, "_sin"}, sin_out, es);
    tick();
    chk({tag, "_done_pulse"}, int'(done_signal), 0);
  endtask

  initial begin
    int lat, ndone, t_first, t_second, held_c, held_s;
    reset        = 1'b1;
    start_signal = 1'b0;
    angle        = '0;
    #12;
    chk("rst_cos", cos_out, 0);
    chk("rst_sin", sin_out, 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_signal), 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    check_angle("a0", 0, 1024, 0);
    check_angle("a804", 804, 724, 724);
    check_angle("am804", -804, 724, -724);
    check_angle("a1608", 1608, 0, 1024);
    check_angle("a2412", 2412, -724, 724);
    check_angle("am3217", -3217, -1024, 0);
    check_angle("a5000", 5000, -1024, 0);
    check_angle("a1609", 1609, ref_cos(1609), ref_sin(1609));
    check_angle("am1609", -1609, ref_cos(-1609), ref_sin(-1609));

    for (int k = 0; k < 16; k++) begin
      int a = int'($urandom_range(0, 8000)) - 4000;
      check_angle("rand", a, ref_cos(a), ref_sin(a));
    end

    held_c = cos_out;
    held_s = sin_out;
    repeat (5) tick();
    chk("hold_cos", cos_out, held_c);
    chk("hold_sin", sin_out, held_s);
    chk("idle_busy", int'(busy), 0);

    // start ignored while busy; angle change after capture has no effect
    start_signal = 1'b1;
    angle        = 0;
    tick();
    start_signal = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin
        start_signal = 1'b1;
        angle        = 1608;
      end else begin
        start_signal = 1'b0;
      end
      if (c == 2) chk("busy_run", int'(busy), 1);
      tick();
      if (done_signal) ndone++;
    end
    start_signal = 1'b0;
    chk("ignore_ndone", ndone, 1);
    chk_tol("ignore_cos", cos_out, 1024);
    chk_tol("ignore_sin", sin_out, 0);

    // held start: back-to-back spacing
    start_signal = 1'b1;
    angle        = 804;
    t_first  = -1;
    t_second = -1;
    for (int c = 1; c <= 60 && t_second < 0; c++) begin
      tick();
      if (done_signal) begin
        if (t_first < 0) t_first = c;
        else             t_second = c;
      end
    end
    start_signal = 1'b0;
    chk("b2b_first", t_first, 13);
    chk("b2b_gap", t_second - t_first, 14);
    repeat (20) tick();

    // reset in the middle of an operation
    start_signal = 1'b1;
    angle        = 1608;
    tick();
    start_signal = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_cos", cos_out, 0);
    chk("mid_rst_sin", sin_out, 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done_signal), 0);
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done_signal) ndone++;
    end
    chk("mid_rst_nodone", ndone, 0);
    check_angle("post_rst", 804, 724, 724);

    run_op(0, lat);
    chk("final_lat", lat, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
